quad_decoder: RTL

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/qdec_pkg.sv | 30 +++
 rtl/qdec_filter.sv | 47 ++++
 rtl/quad_decoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature decoder.
// Holds the {A,B} state enum, the synchronizer depth and the error-counter width.
package qdec_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int ERR_CNT_W   = 8;

   // The encoding is the {A,B} level pair, so a sample casts straight to a state
   typedef enum logic [1:0] {
      S00 = 2'b00,
      S01 = 2'b01,
      S10 = 2'b10,
      S11 = 2'b11
   } qstate_e;

   // A leads B: S00 -> S10 -> S11 -> S01 -> S00
   function automatic logic is_up(qstate_e cur, qstate_e nxt);
      logic up;
      up = 1'b0;
      unique case (cur)
         S00: up = (nxt == S10);
         S10: up = (nxt == S11);
         S11: up = (nxt == S01);
         S01: up = (nxt == S00);
         default: up = 1'b0;
      endcase
      return up;
   endfunction

endpackage

// File: rtl/qdec_filter.sv
// Per-channel glitch filter: output follows input after FILTER_LEN equal, differing samples.
// Ports: clk, rst (sync, high), vld_i/d_i sample in, q_o filtered level, vld_o primed flag.
module qdec_filter
   import qdec_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic vld_i,
   input  logic d_i,
   output logic q_o,
   output logic vld_o
);

   logic [3:0] cnt_q;
   logic       q_q;
   logic       prim_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         q_q    <= 1'b0;
         prim_q <= 1'b0;
      end else if (vld_i) begin
         if (!prim_q) begin
            // First real sample loads directly so the decoder seed is a true level
            q_q    <= d_i;
            prim_q <= 1'b1;
            cnt_q  <= '0;
         end else if (d_i != q_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
               q_q   <= d_i;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign q_o   = q_q;
   assign vld_o = prim_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, optionally filters them (QDEC_FILTER_EN), decodes steps.
// Ports: clk, rst, a_i, b_i in; ce_o, up_o step pulse, err_o illegal pulse, err_cnt_o count.
module quad_decoder
   import qdec_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_i,
   input  logic                 b_i,
   output logic                 ce_o,
   output logic                 up_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_len
      $error("FILTER_LEN out of range 2..15");
   end

   logic [SYNC_STAGES-1:0] sa_q, sb_q, sv_q;

   // sv_q tracks which synchronizer stages hold real post-reset samples
   always_ff @(posedge clk) begin
      if (rst) begin
         sa_q <= '0;
         sb_q <= '0;
         sv_q <= '0;
      end else begin
         sa_q <= {sa_q[SYNC_STAGES-2:0], a_i};
         sb_q <= {sb_q[SYNC_STAGES-2:0], b_i};
         sv_q <= {sv_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   logic src_a, src_b, src_v;

`ifdef QDEC_FILTER_EN
   logic va, vb;

   qdec_filter #(.FILTER_LEN(FILTER_LEN)) u_fa (
      .clk   (clk),
      .rst   (rst),
      .vld_i (sv_q[SYNC_STAGES-1]),
      .d_i   (sa_q[SYNC_STAGES-1]),
      .q_o   (src_a),
      .vld_o (va)
   );

   qdec_filter #(.FILTER_LEN(FILTER_LEN)) u_fb (
      .clk   (clk),
      .rst   (rst),
      .vld_i (sv_q[SYNC_STAGES-1]),
      .d_i   (sb_q[SYNC_STAGES-1]),
      .q_o   (src_b),
      .vld_o (vb)
   );

   assign src_v = va & vb;
`else
   assign src_a = sa_q[SYNC_STAGES-1];
   assign src_b = sb_q[SYNC_STAGES-1];
   assign src_v = sv_q[SYNC_STAGES-1];
`endif

   logic [1:0] smp_q;
   logic       smp_vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q     <= '0;
         smp_vld_q <= 1'b0;
      end else begin
         smp_q     <= {src_a, src_b};
         smp_vld_q <= src_v;
      end
   end

   qstate_e              state_q;
   qstate_e              nxt;
   logic [1:0]           chg;
   logic                 seeded_q;
   logic                 ce_q, up_q, err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      nxt       = qstate_e'(smp_q);
      chg       = smp_q ^ state_q;
      err_cnt_d = err_cnt_q;
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S00;
         seeded_q  <= 1'b0;
         ce_q      <= 1'b0;
         up_q      <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         ce_q  <= 1'b0;
         up_q  <= 1'b0;
         err_q <= 1'b0;
         if (smp_vld_q) begin
            if (!seeded_q) begin
               state_q  <= nxt;
               seeded_q <= 1'b1;
            end else begin
               unique case (1'b1)
                  (chg == 2'b11): begin
                     err_q     <= 1'b1;
                     err_cnt_q <= err_cnt_d;
                     state_q   <= nxt;
                  end
                  (chg == 2'b01 || chg == 2'b10): begin
                     ce_q    <= 1'b1;
                     up_q    <= is_up(state_q, nxt);
                     state_q <= nxt;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign ce_o      = ce_q;
   assign up_o      = up_q;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

endmodule
